// File: rtl/hsk_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hsk_uart_pkg
//  Description : Shared definitions for the housekeeping UART (RX and TX).
//                Holds the receiver state encoding and the oversampling
//                constants that must agree with hsk_uart_brg.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package hsk_uart_pkg;

    // Receiver FSM state encoding
    typedef enum logic [2:0] {
        UART_IDLE   = 3'd0,
        UART_START  = 3'd1,
        UART_DATA   = 3'd2,
        UART_STOP   = 3'd3,
        UART_WAITHI = 3'd4
    } uart_state_e;

    // Ticks of en_16x_baud per serial bit
    localparam int          UART_OVERSAMPLE = 16;
    // Tick count at the middle of the start bit
    localparam logic [3:0]  UART_MID_TICK   = 4'd7;
    // Tick count at which a full bit period has elapsed
    localparam logic [3:0]  UART_LAST_TICK  = 4'd15;

endpackage : hsk_uart_pkg
`default_nettype wire

// File: rtl/hsk_uart_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : hsk_uart_rx_if
//  Description : One-deep AXI4-Stream-style byte channel from the UART
//                receiver to the housekeeping packet parser.
//  Ports       : m_tdata  - received byte (producer -> consumer)
//                m_tvalid - byte available (producer -> consumer)
//                m_tready - consumer accepts byte (consumer -> producer)
//  Revision    : 1.0  initial release
// ============================================================================
interface hsk_uart_rx_if #(
    parameter int NBITS = 8
);
    logic [NBITS-1:0] m_tdata;
    logic             m_tvalid;
    logic             m_tready;

    modport master (
        output m_tdata,
        output m_tvalid,
        input  m_tready
    );

    modport slave (
        input  m_tdata,
        input  m_tvalid,
        output m_tready
    );
endinterface : hsk_uart_rx_if
`default_nettype wire

// File: rtl/hsk_uart_sync.sv
`default_nettype none
// ============================================================================
//  Module      : hsk_uart_sync
//  Description : N-stage flop synchronizer for asynchronous UART pins.
//                All stages reset to 1 so an idle-high line never looks
//                like a start bit coming out of reset.
//  Ports       : clk      - system clock
//                resetn   - synchronous active-low reset
//                d_i      - asynchronous input
//                q_o      - synchronized output (STAGES clk latency)
//  Revision    : 1.0  initial release
// ============================================================================
module hsk_uart_sync #(
    parameter int STAGES = 2
) (
    input  wire logic clk,
    input  wire logic resetn,
    input  wire logic d_i,
    output logic      q_o
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q <= {STAGES{1'b1}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule : hsk_uart_sync
`default_nettype wire

// File: rtl/hsk_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : hsk_uart_rx
//  Description : 8N1 UART receiver. Oversamples rx at 16x baud using the
//                en_16x_baud strobe, checks start/stop bits and presents
//                each good byte on a one-deep stream output.
//  Ports       : clk         - system clock
//                resetn      - synchronous active-low reset
//                en_16x_baud - 16x-baud tick strobe
//                rx          - asynchronous serial input (idle high)
//                m_axis      - byte output channel (master modport)
//                frame_err   - 1-clk pulse on a bad stop bit
//                overrun     - 1-clk pulse when a good byte is dropped
//  Revision    : 1.0  initial release
// ============================================================================
module hsk_uart_rx
    import hsk_uart_pkg::*;
#(
    parameter int NBITS      = 8,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  wire logic       clk,
    input  wire logic       resetn,
    input  wire logic       en_16x_baud,
    input  wire logic       rx,
    hsk_uart_rx_if.master   m_axis,
    output logic            frame_err,
    output logic            overrun
);

    // The tick and bit counters are fixed at 4 and 3 bits, so only the
    // matching parameter range is meaningful.
    if (OVERSAMPLE != UART_OVERSAMPLE) begin : g_bad_oversample
        $error("hsk_uart_rx: OVERSAMPLE must equal UART_OVERSAMPLE");
    end
    if ((NBITS < 1) || (NBITS > 8)) begin : g_bad_nbits
        $error("hsk_uart_rx: NBITS must be in 1..8");
    end

    localparam logic [2:0] LAST_BIT = 3'(NBITS - 1);

    logic             rx_s;
    uart_state_e      state_q, state_d;
    logic [3:0]       tcnt_q,  tcnt_d;
    logic [2:0]       bcnt_q,  bcnt_d;
    logic [NBITS-1:0] shreg_q, shreg_d;
    logic [NBITS-1:0] tdata_q, tdata_d;
    logic             tvalid_q, tvalid_d;
    logic             ferr_q,  ferr_d;
    logic             ovr_q,   ovr_d;
    logic             buf_free;

    hsk_uart_sync #(
        .STAGES (2)
    ) u_rx_sync (
        .clk    (clk),
        .resetn (resetn),
        .d_i    (rx),
        .q_o    (rx_s)
    );

    // A held byte being accepted this cycle frees the slot for a new load.
    assign buf_free = !tvalid_q || m_axis.m_tready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= UART_IDLE;
            tcnt_q   <= '0;
            bcnt_q   <= '0;
            shreg_q  <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tcnt_q   <= tcnt_d;
            bcnt_q   <= bcnt_d;
            shreg_q  <= shreg_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        bcnt_d   = bcnt_q;
        shreg_d  = shreg_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        ferr_d   = 1'b0;
        ovr_d    = 1'b0;

        if (tvalid_q && m_axis.m_tready) begin
            tvalid_d = 1'b0;
        end

        case (state_q)
            UART_IDLE: begin
                if (en_16x_baud && !rx_s) begin
                    state_d = UART_START;
                    tcnt_d  = '0;
                end
            end

            UART_START: begin
                if (en_16x_baud) begin
                    if (tcnt_q == UART_MID_TICK) begin
                        if (rx_s) begin
                            state_d = UART_IDLE;
                        end else begin
                            state_d = UART_DATA;
                            tcnt_d  = '0;
                            bcnt_d  = '0;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 4'd1;
                    end
                end
            end

            // tcnt wraps 15 -> 0, so each later bit is sampled a full bit
            // period after the previous one without an explicit clear.
            UART_DATA: begin
                if (en_16x_baud) begin
                    tcnt_d = tcnt_q + 4'd1;
                    if (tcnt_q == UART_LAST_TICK) begin
                        shreg_d = {rx_s, shreg_q[NBITS-1:1]};
                        bcnt_d  = bcnt_q + 3'd1;
                        if (bcnt_q == LAST_BIT) begin
                            state_d = UART_STOP;
                        end
                    end
                end
            end

            UART_STOP: begin
                if (en_16x_baud) begin
                    tcnt_d = tcnt_q + 4'd1;
                    if (tcnt_q == UART_LAST_TICK) begin
                        if (rx_s) begin
                            if (buf_free) begin
                                tdata_d  = shreg_q;
                                tvalid_d = 1'b1;
                            end else begin
                                ovr_d = 1'b1;
                            end
                            state_d = UART_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = UART_WAITHI;
                        end
                    end
                end
            end

            // Wait out a break condition so a long low line is not
            // re-detected as a string of start bits.
            UART_WAITHI: begin
                if (rx_s) begin
                    state_d = UART_IDLE;
                end
            end

            default: begin
                state_d = UART_IDLE;
            end
        endcase
    end

    assign m_axis.m_tdata  = tdata_q;
    assign m_axis.m_tvalid = tvalid_q;
    assign frame_err       = ferr_q;
    assign overrun         = ovr_q;

endmodule : hsk_uart_rx
`default_nettype wire
